axi_uart_tx_wrapper: RTL and testbench

AXI4-Lite slave that accepts MIDI bytes from the processor, buffers them in a TX FIFO, and serializes them onto a UART line (start bit, 8 data bits, 1 stop bit). It is the transmit counterpart of the MIDI receive wrapper and shares the same register-slave style and the same UART bit conventions. A status register and a level interrupt let software pace its writes.

---
 rtl/axi_uart_tx_wrapper.sv | 204 ++++++++++++++++++++
 tb/tb_axi_uart_tx_wrapper.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uart_tx_wrapper.sv
// AXI4-Lite slave feeding a byte FIFO that is serialized onto an 8N1 UART line.
// Register map: 0x0 TXDATA (write-only), 0x4 STATUS (read-only).
module axi_uart_tx_wrapper #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_LSB_FIRST    = 1,
  parameter int C_FIFO_DEPTH   = 8,
  parameter int C_CLKS_PER_BIT = 3200
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        midi_out,
  output logic                        midi_tx_intr
);

  localparam int AW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int CW = (C_CLKS_PER_BIT > 1) ? $clog2(C_CLKS_PER_BIT) : 1;
  localparam int RW = C_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, fifo_full, push, pop, room;

  state_t        state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt, bit_sel;
  logic [7:0]    shreg;
  logic          bit_done, tx_busy, line_bit;

  logic          wr_fire, wr_sel_tx, wr_err, rd_fire, rd_err;
  logic [C_DATA_WIDTH-1:0] status_word, rd_val;
  logic          unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[C_DATA_WIDTH-1:8], s_axi_wstrb[C_DATA_WIDTH/8-1:1]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(C_FIFO_DEPTH));
  assign tx_busy    = (state != IDLE);

  // A same-cycle pop frees a slot, so a full FIFO can still accept the push.
  assign room      = ~fifo_full | pop;
  assign wr_fire   = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign wr_sel_tx = (s_axi_awaddr[C_ADDR_WIDTH-1:2] == RW'(0));
  assign push      = wr_fire & wr_sel_tx & s_axi_wstrb[0] & room;
  assign wr_err    = ~wr_sel_tx | (s_axi_wstrb[0] & ~room);
  assign rd_fire   = s_axi_arready & s_axi_arvalid;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = fifo_empty;
    status_word[1]    = fifo_full;
    status_word[2]    = tx_busy;
    status_word[15:8] = 8'(count);
    rd_val = '0;
    rd_err = 1'b0;
    case (s_axi_araddr[C_ADDR_WIDTH-1:2])
      RW'(0):  rd_val = '0;
      RW'(1):  rd_val = status_word;
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rdata  <= '0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (push) mem[wr_ptr] <= s_axi_wdata[7:0];
    if (pop)  shreg <= mem[rd_ptr];
  end

  assign bit_done = (clk_cnt == CW'(C_CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: if (bit_done) begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = 3'd0;
        state_nxt   = DATA;
      end
      DATA: if (bit_done) begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (bit_done) begin
        clk_cnt_nxt = '0;
        // Chain straight into the next start bit when more bytes are waiting.
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bit_sel  = (C_LSB_FIRST != 0) ? bit_idx : (3'd7 - bit_idx);
  assign line_bit = (state == START) ? 1'b0 : (state == DATA) ? shreg[bit_sel] : 1'b1;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      midi_out     <= 1'b1;
      midi_tx_intr <= 1'b1;
    end else begin
      state        <= state_nxt;
      clk_cnt      <= clk_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      midi_out     <= line_bit;
      midi_tx_intr <= fifo_empty & ~tx_busy;
    end
  end

endmodule

// File: tb/tb_axi_uart_tx_wrapper.sv
// Directed bench for axi_uart_tx_wrapper: register table, frame timing and corner sequences.
module tb_axi_uart_tx_wrapper;

  localparam int LOGN = 4096;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, midi_lsb, intr;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m, midi_msb, intr_m;
  logic [1:0]  bresp_m, rresp_m;
  logic [31:0] rdata_m;

  int tests = 0, fails = 0, cyc = 0;
  logic lsb_log [LOGN];
  logic msb_log [LOGN];
  logic intr_log[LOGN];

  typedef struct packed {
    logic        is_rd;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl_a[7];
  vec_t tbl_b[10];

  axi_uart_tx_wrapper #(.C_LSB_FIRST(1), .C_CLKS_PER_BIT(4)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .midi_out(midi_lsb), .midi_tx_intr(intr));

  axi_uart_tx_wrapper #(.C_LSB_FIRST(0), .C_CLKS_PER_BIT(4)) dut_msb (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready_m),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready_m),
    .s_axi_bresp(bresp_m), .s_axi_bvalid(bvalid_m), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready_m),
    .s_axi_rdata(rdata_m), .s_axi_rresp(rresp_m), .s_axi_rvalid(rvalid_m), .s_axi_rready(rready),
    .midi_out(midi_msb), .midi_tx_intr(intr_m));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      lsb_log[cyc]  = midi_lsb;
      msb_log[cyc]  = midi_msb;
      intr_log[cyc] = intr;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=0x%08h required=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int hs);
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    check("awready_seen", n, {31'b0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    hs = cyc;
    resp = bresp;
    check("bvalid_rise", hs, {31'b0, bvalid}, 32'd1);
    if (bready) begin @(posedge clk); #1; end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    check("arready_seen", n, {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_rise", cyc, {31'b0, rvalid}, 32'd1);
    data = rdata; resp = rresp;
    if (rready) begin
      @(posedge clk); #1;
      check("rdata_clear", cyc, rdata, 32'd0);
    end
  endtask

  function automatic logic [9:0] get_frame(input int s, input bit msb);
    logic [9:0] v = '0;
    for (int k = 0; k < 10; k++) begin
      if (s + 2 + 4*k < LOGN) v[k] = msb ? msb_log[s + 2 + 4*k] : lsb_log[s + 2 + 4*k];
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int i, output int hs);
    logic [31:0] d;
    logic [1:0]  r;
    hs = 0;
    if (v.is_rd) begin
      axi_read(v.addr, d, r);
      check("rd_resp", i, {30'b0, r}, {30'b0, v.resp});
      check("rd_data", i, d, v.rdata);
    end else begin
      axi_write(v.addr, v.data, v.strb, r, hs);
      check("wr_resp", i, {30'b0, r}, {30'b0, v.resp});
    end
  endtask

  initial begin
    int h, h1, h0, lows;
    logic [1:0]  r;
    logic [31:0] d;

    tbl_a[0] = '{1'b1, 4'h4, 32'h0,  4'h0, OKAY,   32'h1};
    tbl_a[1] = '{1'b1, 4'h0, 32'h0,  4'h0, OKAY,   32'h0};
    tbl_a[2] = '{1'b1, 4'hC, 32'h0,  4'h0, SLVERR, 32'h0};
    tbl_a[3] = '{1'b0, 4'h8, 32'h5A, 4'hF, SLVERR, 32'h0};
    tbl_a[4] = '{1'b1, 4'h4, 32'h0,  4'h0, OKAY,   32'h1};
    tbl_a[5] = '{1'b0, 4'h0, 32'h77, 4'h0, OKAY,   32'h0};
    tbl_a[6] = '{1'b1, 4'h4, 32'h0,  4'h0, OKAY,   32'h1};
    for (int i = 0; i < 10; i++)
      tbl_b[i] = '{1'b0, 4'h0, 32'(i + 1), 4'h1, (i == 9) ? SLVERR : OKAY, 32'h0};

    // reset, then idle
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_line", 0, {31'b0, midi_lsb}, 32'd1);
    check("rst_intr", 0, {31'b0, intr}, 32'd1);
    check("rst_hs", 0, {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("rst_regs", 0, {28'b0, bresp, rresp}, 32'd0);
    check("rst_rdata", 0, rdata, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl_a[i], i, h);

    // single 0x90 frame on both bit orders
    axi_write(4'h0, 32'h90, 4'h1, r, h);
    check("tx90_resp", 0, {30'b0, r}, {30'b0, OKAY});
    wait_cyc(h + 50);
    check("tx90_pre_low", 0, {31'b0, lsb_log[h + 1]}, 32'd1);
    check("tx90_low_at_2", 0, {31'b0, lsb_log[h + 2]}, 32'd0);
    check("tx90_lsb_frame", 0, {22'b0, get_frame(h + 2, 1'b0)}, 32'h320);
    check("tx90_msb_frame", 0, {22'b0, get_frame(h + 2, 1'b1)}, 32'h212);
    check("tx90_intr_busy", 0, {31'b0, intr_log[h + 20]}, 32'd0);
    check("tx90_intr_done", 0, {31'b0, intr_log[h + 44]}, 32'd1);
    check("tx90_idle_line", 0, {31'b0, lsb_log[h + 45]}, 32'd1);

    // ten back-to-back writes; the tenth finds the FIFO full
    h1 = 0;
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl_b[i], i, h);
      if (i == 0) h1 = h;
    end
    axi_read(4'h4, d, r);
    check("full_status", 0, d, 32'h0000_0806);
    check("full_status_resp", 0, {30'b0, r}, {30'b0, OKAY});
    wait_cyc(h1 + 2 + 40*9 + 8);
    for (int j = 0; j < 9; j++)
      check("b2b_frame", j, {22'b0, get_frame(h1 + 2 + 40*j, 1'b0)}, {22'b0, 1'b1, 8'(j + 1), 1'b0});
    check("b2b_idle_line", 0, {31'b0, lsb_log[h1 + 2 + 40*9 + 2]}, 32'd1);
    check("b2b_intr_done", 0, {31'b0, intr}, 32'd1);

    // responses held while bready / rready are low
    bready = 1'b0;
    axi_write(4'h8, 32'h0, 4'hF, r, h);
    check("hold_bresp", 0, {30'b0, r}, {30'b0, SLVERR});
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_b", i, {30'b0, bvalid, awready}, 32'h2);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    check("hold_b_release", 0, {31'b0, bvalid}, 32'd0);

    rready = 1'b0;
    axi_read(4'hC, d, r);
    check("hold_rresp", 0, {30'b0, r}, {30'b0, SLVERR});
    check("hold_rdata", 0, d, 32'd0);
    arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_r", i, {30'b0, rvalid, arready}, 32'h2);
    end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    check("hold_r_release", 0, {31'b0, rvalid}, 32'd0);
    axi_read(4'h4, d, r);
    check("hold_status", 0, d, 32'h1);

    // reset during data bit 3 with three bytes still queued
    axi_write(4'h0, 32'h55, 4'h1, r, h0);
    axi_write(4'h0, 32'hAA, 4'h1, r, h);
    axi_write(4'h0, 32'h33, 4'h1, r, h);
    axi_write(4'h0, 32'hCC, 4'h1, r, h);
    wait_cyc(h0 + 18);
    check("midrst_bit3_low", 0, {31'b0, midi_lsb}, 32'd0);
    rst = 1'b1;
    wait_cyc(h0 + 19);
    check("midrst_line_high", 0, {31'b0, midi_lsb}, 32'd1);
    check("midrst_intr", 0, {31'b0, intr}, 32'd1);
    rst = 1'b0;
    wait_cyc(h0 + 110);
    lows = 0;
    for (int c = h0 + 19; c < h0 + 109; c++) if (lsb_log[c] !== 1'b1) lows++;
    check("midrst_no_frames", 0, 32'(lows), 32'd0);
    axi_read(4'h4, d, r);
    check("midrst_status", 0, d, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
